// File: rtl/lsu_mem.sv
// ---------------------------------------------------------------------------
// lsu_mem -- single-port load/store memory with a fixed response latency.
//
// One request at a time: a request is accepted in IDLE, waits LATENCY cycles
// in WAIT, then produces a one-cycle response in RESP. Stores commit and loads
// sample the array on the edge that enters RESP. Loads are lane-extracted and
// sign- or zero-extended. Addresses wrap modulo DEPTH*4 bytes.
//
// Parameters
//   DEPTH    memory size in 32-bit words (power of two, 4..65536)
//   LATENCY  wait cycles between acceptance and response (0..15)
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset (control state only)
//   req_valid     request presented
//   req_ready     block can accept a request (IDLE only)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10/11 word
//   req_unsigned  zero-extend loads
//   req_addr      byte address
//   req_wdata     store data (low bits for byte/half)
//   rsp_valid     one-cycle response pulse
//   rsp_rdata     extended load data, 0 for stores and outside RESP
//   rsp_err       misaligned access flag
//   busy          FSM not in IDLE
//
// Build option
//   LSU_MEM_MISALIGN_TRAP_EN  defined: misaligned half/word accesses respond
//                             with rsp_err=1, rsp_rdata=0 and no write.
//                             undefined: low address bits are forced to
//                             natural alignment and rsp_err is always 0.
// ---------------------------------------------------------------------------
module lsu_mem #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int CNT_W  = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Byte offset after forcing natural alignment for halves and words.
  function automatic logic [1:0] align_off(input logic [1:0] sz,
                                           input logic [1:0] lo);
    case (sz)
      2'b00:   align_off = lo;
      2'b01:   align_off = {lo[1], 1'b0};
      default: align_off = 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz,
                                         input logic [1:0] lo);
    case (sz)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = lo[0];
      default: is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz,
                                           input logic [1:0] off);
    case (sz)
      2'b00:   lane_mask = 4'b0001 << off;
      2'b01:   lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // Extract the addressed lane and extend it to the full data width.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] word,
                                                 input logic [1:0]        sz,
                                                 input logic [1:0]        off,
                                                 input logic              uns);
    logic [DATA_W-1:0]  shifted;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    shifted = word >> {off, 3'b000};
    sb      = shifted[7:0];
    sh      = shifted[15:0];
    case (sz)
      2'b00:   load_ext = uns ? {24'd0, shifted[7:0]}  : DATA_W'(sb);
      2'b01:   load_ext = uns ? {16'd0, shifted[15:0]} : DATA_W'(sh);
      default: load_ext = shifted;
    endcase
  endfunction

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;

  logic              we_p0;
  logic [1:0]        size_p0;
  logic              uns_p0;
  logic [AW+1:0]     addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic [DATA_W-1:0] rdata_p1;
  logic              err_p1;
  logic              vld_p1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              op_we;
  logic [1:0]        op_size;
  logic              op_uns;
  logic [AW+1:0]     op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [1:0]        op_off;
  logic [AW-1:0]     op_idx;
  logic              op_err;
  logic [3:0]        op_mask;
  logic [DATA_W-1:0] op_wshift;

  // Address bits above the array are ignored, giving wrap-around.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, req_addr[31:AW+2]};

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && (state == IDLE);

  // With LATENCY=0 the commit edge is the acceptance edge, so the operation
  // must come straight from the request port rather than the capture regs.
  always_comb begin
    op_we    = we_p0;
    op_size  = size_p0;
    op_uns   = uns_p0;
    op_addr  = addr_p0;
    op_wdata = wdata_p0;
    if (state == IDLE) begin
      op_we    = req_we;
      op_size  = req_size;
      op_uns   = req_unsigned;
      op_addr  = req_addr[AW+1:0];
      op_wdata = req_wdata;
    end
  end

  assign enter_resp = !rst &&
                      ((accept && (LATENCY == 0)) ||
                       ((state == WAIT) && (cnt <= CNT_W'(1))));

  assign op_off    = align_off(op_size, op_addr[1:0]);
  assign op_idx    = op_addr[AW+1:2];
  assign op_mask   = lane_mask(op_size, op_off);
  assign op_wshift = op_wdata << {op_off, 3'b000};

`ifdef LSU_MEM_MISALIGN_TRAP_EN
  assign op_err = is_misaligned(op_size, op_addr[1:0]);
`else
  logic unused_misalign;
  assign unused_misalign = is_misaligned(op_size, op_addr[1:0]);
  assign op_err          = 1'b0;
`endif

  // Control: FSM and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (LATENCY == 0) begin
              state <= RESP;
              cnt   <= '0;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY);
            end
          end
        end
        WAIT: begin
          if (cnt <= CNT_W'(1)) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Stage p0: request capture on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      size_p0  <= req_size;
      uns_p0   <= req_unsigned;
      addr_p0  <= req_addr[AW+1:0];
      wdata_p0 <= req_wdata;
    end
  end

  // Memory array: lane-masked store commit on the edge entering RESP
  always_ff @(posedge clk) begin
    if (enter_resp && op_we && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (op_mask[b]) mem[op_idx][8*b +: 8] <= op_wshift[8*b +: 8];
      end
    end
  end

  // Stage p1: response data sampled on the edge entering RESP
  always_ff @(posedge clk) begin
    if (enter_resp) begin
      err_p1   <= op_err;
      rdata_p1 <= (op_we || op_err) ? '0
                                    : load_ext(mem[op_idx], op_size, op_off, op_uns);
    end
  end

  assign vld_p1    = (state == RESP);
  assign rsp_valid = vld_p1;
  assign rsp_rdata = vld_p1 ? rdata_p1 : '0;
  assign rsp_err   = vld_p1 && err_p1;

endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning memory size in 32-bit words (power of two, 4..65536).
REQ-002 The block SHALL have parameter LATENCY, default 1, meaning wait cycles between request acceptance and response (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, with synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit, meaning a request is presented.
REQ-006 The block SHALL have port req_ready, output, 1 bit, meaning the block can accept a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = treated as word.
REQ-009 The block SHALL have port req_unsigned, input, 1 bit, meaning zero-extend loads (lbu/lhu); ignored for stores and words.
REQ-010 The block SHALL have port req_addr, input, 32 bits, the byte address.
REQ-011 The block SHALL have port req_wdata, input, 32 bits, the store data, taken from the low bits for byte and half.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit, a one-cycle pulse marking the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits, the extended load data; 0 for stores.
REQ-014 The block SHALL have port rsp_err, output, 1 bit, flagging a misaligned access (see Configuration).
REQ-015 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid=1 and req_ready=1, at which point all req_* fields are captured.
REQ-018 On acceptance the FSM SHALL go to WAIT with a counter loaded with LATENCY; if LATENCY=0 it SHALL go directly to RESP.
REQ-019 In WAIT the counter SHALL decrement each cycle; the FSM SHALL move to RESP on the edge where the counter equals 1.
REQ-020 rsp_valid SHALL be high for exactly the one cycle spent in RESP, and the FSM SHALL then return to IDLE.
REQ-021 Accept-to-rsp_valid latency SHALL be LATENCY+1 cycles; maximum throughput SHALL be one request per LATENCY+2 cycles.
REQ-022 The word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-023 A store SHALL update only the addressed byte lanes, on the edge that enters RESP.
REQ-024 A load SHALL sample the memory on the edge that enters RESP, extract the addressed lane, and sign- or zero-extend it per req_unsigned.
REQ-025 rsp_rdata and rsp_err SHALL be held stable during RESP and SHALL be 0 outside RESP.
REQ-026 req_valid while not ready SHALL be ignored; no request is queued.

Reset
REQ-027 With rst=1 on an edge, the FSM SHALL go to IDLE and the counter to 0, giving req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 and busy=0 in the next cycle.
REQ-028 Reset during WAIT SHALL abort the transaction: no store commit and no response.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 rst SHALL take priority over a simultaneous req_valid.

Configuration
REQ-031 Macro LSU_MEM_MISALIGN_TRAP_EN defined: a half with addr[0]=1, or a word with addr[1:0]!=0, SHALL respond with rsp_err=1 and rsp_rdata=0, perform no write, and keep normal latency.
REQ-032 Macro LSU_MEM_MISALIGN_TRAP_EN undefined: misaligned low address bits SHALL be forced to natural alignment, and rsp_err SHALL be constant 0.

Verification
REQ-033 With LATENCY=2: store word 0xDEADBEEF to 0x10 accepted at cycle N -> rsp_valid only at N+3 and req_ready=0 during N+1..N+3; a later load word from 0x10 -> 0xDEADBEEF.
REQ-034 Store byte 0x80 to 0x21, then load byte from 0x21 -> 0xFFFFFF80; lbu from 0x21 -> 0x00000080; lw from 0x20 shows only byte 1 changed.
REQ-035 With DEPTH=256: store word 0x12345678 to 0x400 -> lw from 0x0 returns 0x12345678 (wrap).
REQ-036 With the macro defined: lw from 0x2 -> rsp_err=1 and rsp_rdata=0; sw to 0x6 leaves the word at 0x4 unchanged. With the macro undefined: the same sw writes the word at 0x4.
REQ-037 rst asserted in WAIT during sw 0xAAAA5555 to 0x8 -> no rsp_valid, the word at 0x8 keeps its old value, req_ready=1 in the next cycle.
REQ-038 With LATENCY=0, req_valid held high continuously -> accept every 2nd cycle, and rsp_valid pulses on alternate cycles.
